// File: rtl/exu_md_stage.sv
// Execute stage: single-cycle ALU plus iterative RV32M multiply/divide behind a valid/ready
// handshake. Holds one operation at a time and carries an opaque tag alongside the result.
module exu_md_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 64,
  parameter bit          MUL_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_md,
  input  logic [3:0]       in_alu_op,
  input  logic             in_inv,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;
  logic [2:0]            f3_q, f3_d;
  logic                  neg_q, neg_d;
  logic                  rneg_q, rneg_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_result_q, out_result_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;

  logic                  accept;
  logic [ShW-1:0]        shamt;
  logic [XLEN-1:0]       alu_res;
  logic                  a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic                  div_zero, div_ovf;
  logic [XLEN-1:0]       special_res;
  logic [2*XLEN-1:0]     fm_a, fm_b, fm_p;
  logic [XLEN-1:0]       fm_res;
  logic                  fast_path;
  logic [XLEN-1:0]       fast_res;
  logic [XLEN-1:0]       mul_addend;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic [XLEN:0]         div_shift, div_trial;
  logic [2*XLEN-1:0]     div_next;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix, fix_res;

  assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  assign shamt = in_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (in_alu_op)
      4'd0:    alu_res = in_a + in_b;
      4'd1:    alu_res = in_a - in_b;
      4'd2:    alu_res = in_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      4'd5:    alu_res = in_a ^ in_b;
      4'd6:    alu_res = in_a >> shamt;
      4'd7:    alu_res = $signed(in_a) >>> shamt;
      4'd8:    alu_res = in_a | in_b;
      4'd9:    alu_res = in_a & in_b;
      default: alu_res = '0;
    endcase
    alu_res[0] = alu_res[0] ^ in_inv;
  end

  // Operand signedness by funct3: MULH, MULHSU, DIV, REM treat a as signed; MULH, DIV, REM b.
  assign a_signed = (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                    (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
  assign b_signed = (in_funct3 == 3'd1) || (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
  assign sa       = a_signed && in_a[XLEN-1];
  assign sb       = b_signed && in_b[XLEN-1];
  assign mag_a    = sa ? -in_a : in_a;
  assign mag_b    = sb ? -in_b : in_b;

  assign div_zero    = (in_b == '0);
  assign div_ovf     = b_signed && (in_a == MinVal) && (in_b == '1);
  assign special_res = in_funct3[1] ? (div_zero ? in_a : '0) : (div_zero ? '1 : in_a);

  // Single-cycle multiply on sign/zero-extended operands; low 2*XLEN bits are exact.
  assign fm_a   = a_signed ? {{XLEN{in_a[XLEN-1]}}, in_a} : {{XLEN{1'b0}}, in_a};
  assign fm_b   = b_signed ? {{XLEN{in_b[XLEN-1]}}, in_b} : {{XLEN{1'b0}}, in_b};
  assign fm_p   = fm_a * fm_b;
  assign fm_res = (in_funct3 == 3'd0) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];

  assign fast_path = !in_md || (in_funct3[2] ? (div_zero || div_ovf) : MUL_FAST);
  assign fast_res  = !in_md ? alu_res : (in_funct3[2] ? special_res : fm_res);

  // Shift-add: acc holds {partial product, remaining multiplier bits}.
  assign mul_addend = acc_q[0] ? mcand_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}.
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_trial = div_shift - {1'b0, mcand_q};
  assign div_next  = {div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0],
                      acc_q[XLEN-2:0], ~div_trial[XLEN]};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (f3_q[2]) begin
      fix_res = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_res = (f3_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    f3_d         = f3_q;
    neg_d        = neg_q;
    rneg_d       = rneg_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = StIdle;
      cnt_d       = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (fast_path) begin
              out_valid_d  = 1'b1;
              out_result_d = fast_res;
              out_tag_d    = in_tag;
            end else begin
              state_d = StCalc;
              cnt_d   = CntW'(XLEN);
              acc_d   = {{XLEN{1'b0}}, mag_a};
              mcand_d = mag_b;
              f3_d    = in_funct3;
              neg_d   = sa ^ sb;
              rneg_d  = sa;
              tag_d   = in_tag;
            end
          end
        end
        StCalc: begin
          acc_d = f3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          out_valid_d  = 1'b1;
          out_result_d = fix_res;
          out_tag_d    = tag_q;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      f3_q         <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      f3_q         <= f3_d;
      neg_q        <= neg_d;
      rneg_q       <= rneg_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_exu_md_stage.sv
// Bench for exu_md_stage: iterative and fast-multiply instances share stimulus and are checked
// every cycle against a latency/arithmetic reference model, plus directed literal checks.
module tb_exu_md_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 64;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_md, in_inv, out_ready;
  logic [3:0]        op;
  logic [2:0]        f3;
  logic [XLEN-1:0]   a, b;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        rdy, ov;
  logic [XLEN-1:0]   res  [2];
  logic [TAG_W-1:0]  otag [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int               m_busy [2];
  bit               m_ov   [2];
  logic [XLEN-1:0]  m_res  [2];
  logic [XLEN-1:0]  p_res  [2];
  logic [TAG_W-1:0] m_tag  [2];
  logic [TAG_W-1:0] p_tag  [2];

  always #5 clk = ~clk;

  exu_md_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_FAST(1'b0)) u_dut_iter (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_md(in_md), .in_alu_op(op), .in_inv(in_inv), .in_funct3(f3), .in_a(a), .in_b(b),
    .in_tag(tag), .out_valid(ov[0]), .out_ready(out_ready), .out_result(res[0]),
    .out_tag(otag[0])
  );

  exu_md_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_FAST(1'b1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_md(in_md), .in_alu_op(op), .in_inv(in_inv), .in_funct3(f3), .in_a(a), .in_b(b),
    .in_tag(tag), .out_valid(ov[1]), .out_ready(out_ready), .out_result(res[1]),
    .out_tag(otag[1])
  );

  task automatic chk(input string nm, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, want %0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from RV32 rules with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic md, input logic [3:0] opc,
                                          input logic inv, input logic [2:0] fn,
                                          input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] r;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sh = int'(y[4:0]);
    r  = '0;
    p  = '0;
    if (!md) begin
      case (opc)
        4'd0: r = 32'(ux + uy);
        4'd1: r = 32'(ux - uy);
        4'd2: r = 32'(ux << sh);
        4'd3: r = (sx < sy) ? 32'd1 : 32'd0;
        4'd4: r = (ux < uy) ? 32'd1 : 32'd0;
        4'd5: r = x ^ y;
        4'd6: r = 32'(ux >> sh);
        4'd7: r = 32'(sx >>> sh);
        4'd8: r = x | y;
        4'd9: r = x & y;
        default: r = '0;
      endcase
      r[0] = r[0] ^ inv;
    end else if (!fn[2]) begin
      case (fn)
        3'd0: p = sx * sy;
        3'd1: p = sx * sy;
        3'd2: p = sx * uy;
        default: p = ux * uy;
      endcase
      r = (fn == 3'd0) ? p[31:0] : p[63:32];
    end else if (y == 32'd0) begin
      r = fn[1] ? x : 32'hFFFF_FFFF;
    end else if (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = fn[1] ? 32'd0 : x;
    end else begin
      case (fn)
        3'd4: r = 32'(sx / sy);
        3'd5: r = 32'(ux / uy);
        3'd6: r = 32'(sx % sy);
        default: r = 32'(ux % uy);
      endcase
    end
    return r;
  endfunction

  function automatic bit is_fast(input int inst, input logic md, input logic [2:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    if (!md) return 1'b1;
    if (!fn[2]) return (inst == 1);
    return (y == 32'd0) || (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic bit rdy_exp(input int i);
    return (m_busy[i] == 0) && (!m_ov[i] || out_ready);
  endfunction

  // Model: fast ops appear one cycle after accept, iterative ones XLEN+2 cycles after.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit r_e;
      r_e = rdy_exp(i);
      if (!rst_n) begin
        m_busy[i] = 0;
        m_ov[i]   = 1'b0;
        m_res[i]  = '0;
        m_tag[i]  = '0;
      end else if (flush) begin
        m_busy[i] = 0;
        m_ov[i]   = 1'b0;
      end else begin
        if (m_ov[i] && out_ready) m_ov[i] = 1'b0;
        if (m_busy[i] > 0) begin
          m_busy[i]--;
          if (m_busy[i] == 0) begin
            m_ov[i]  = 1'b1;
            m_res[i] = p_res[i];
            m_tag[i] = p_tag[i];
          end
        end else if (in_valid && r_e) begin
          if (is_fast(i, in_md, f3, a, b)) begin
            m_ov[i]  = 1'b1;
            m_res[i] = ref_res(in_md, op, in_inv, f3, a, b);
            m_tag[i] = tag;
          end else begin
            m_busy[i] = XLEN + 1;
            p_res[i]  = ref_res(in_md, op, in_inv, f3, a, b);
            p_tag[i]  = tag;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 64'(rdy[i]), 64'(rdy_exp(i)));
        chk("out_valid", i, 64'(ov[i]), 64'(m_ov[i]));
        if (m_ov[i]) begin
          chk("out_result", i, 64'(res[i]), 64'(m_res[i]));
          chk("out_tag", i, otag[i], m_tag[i]);
        end
      end
    end
  end

  task automatic drive(input logic md, input logic [3:0] opc, input logic inv,
                       input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] t);
    in_md = md; op = opc; in_inv = inv; f3 = fn; a = x; b = y; tag = t;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  // Issue one op to both instances together and check result, tag and latency of each.
  task automatic op_both(input string nm, input logic md, input logic [3:0] opc,
                         input logic inv, input logic [2:0] fn, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat0,
                         input int lat1);
    int lat [2];
    logic [31:0] r [2];
    logic [63:0] t [2];
    logic [63:0] tg;
    int busy_rdy;
    drain();
    tg = {$urandom, $urandom};
    drive(md, opc, inv, fn, x, y, tg);
    in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_accept_rdy"}, 0, 64'(rdy), 64'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat[0] = 0; lat[1] = 0; busy_rdy = 0;
    r[0] = '0; r[1] = '0; t[0] = '0; t[1] = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!ov[0] && lat[0] == 0 && rdy[0]) busy_rdy++;
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = k; r[i] = res[i]; t[i] = otag[i];
        end
      end
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_result"}, i, 64'(r[i]), 64'(exp));
      chk({nm, "_tag"}, i, t[i], tg);
    end
    chk({nm, "_latency"}, 0, 64'(lat[0]), 64'(lat0));
    chk({nm, "_latency"}, 1, 64'(lat[1]), 64'(lat1));
    chk({nm, "_busy_in_ready"}, 0, 64'(busy_rdy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Start a DIVU, then at CALC cycle 10 either flush or pulse reset.
  task automatic kill_mid_calc(input bit use_reset);
    int ov_cnt;
    drain();
    drive(1'b1, 4'd0, 1'b0, 3'd5, 32'd1000, 32'd7, 64'hD1D1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_reset) rst_n = 1'b0;
    else begin
      flush = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd1, 32'd2, 64'hADD0);
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk(use_reset ? "rst_in_ready" : "flush_in_ready", 0, 64'(rdy), 64'd3);
    chk(use_reset ? "rst_out_valid" : "flush_out_valid", 0, 64'(ov), 64'd0);
    if (use_reset) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_out_result", i, 64'(res[i]), 64'd0);
        chk("rst_out_tag", i, otag[i], 64'd0);
      end
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("flush_next_add_valid", 0, 64'(ov), 64'd3);
      chk("flush_next_add_result", 0, 64'(res[0]), 64'd3);
      chk("flush_next_add_tag", 0, otag[0], 64'hADD0);
    end
    ov_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (ov != 2'b00) ov_cnt++;
    end
    chk(use_reset ? "rst_killed_op_silent" : "flush_killed_op_silent", 0, 64'(ov_cnt), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_out_valid", i, 64'(ov[i]), 64'd0);
      chk("reset_in_ready", i, 64'(rdy[i]), 64'd1);
      chk("reset_out_result", i, 64'(res[i]), 64'd0);
      chk("reset_out_tag", i, otag[i], 64'd0);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ALU ops, one result per cycle.
    drain();
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd5, 32'd7, 64'h1111);
    in_valid = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 4'd1, 1'b0, 3'd0, 32'd3, 32'd5, 64'h2222);
    @(negedge clk);
    chk("b2b_add_valid", 0, 64'(ov[0]), 64'd1);
    chk("b2b_add_result", 0, 64'(res[0]), 64'h0000_000C);
    chk("b2b_add_tag", 0, otag[0], 64'h1111);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sub_valid", 0, 64'(ov[0]), 64'd1);
    chk("b2b_sub_result", 0, 64'(res[0]), 64'hFFFF_FFFE);
    chk("b2b_sub_tag", 0, otag[0], 64'h2222);
    @(posedge clk);
    #1;

    // SLT with inversion under a 3-cycle output stall; queued ADD enters on the transfer.
    drain();
    out_ready = 1'b0;
    drive(1'b0, 4'd3, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 64'h3333);
    in_valid = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 4'd0, 1'b0, 3'd0, 32'h10, 32'h20, 64'h4444);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 0, 64'(ov[0]), 64'd1);
      chk("stall_result", 0, 64'(res[0]), 64'd0);
      chk("stall_tag", 0, otag[0], 64'h3333);
      chk("stall_in_ready", 0, 64'(rdy[0]), 64'd0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", 0, 64'(rdy[0]), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_next_result", 0, 64'(res[0]), 64'h30);
    chk("stall_next_tag", 0, otag[0], 64'h4444);
    @(posedge clk);
    #1;

    op_both("div_neg", 1'b1, 4'd0, 1'b0, 3'd4, -32'd7, 32'd2, 32'hFFFF_FFFD, 34, 34);
    op_both("rem_neg", 1'b1, 4'd0, 1'b0, 3'd6, -32'd7, 32'd2, 32'hFFFF_FFFF, 34, 34);
    op_both("divu", 1'b1, 4'd0, 1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 34, 34);
    op_both("div_by_zero", 1'b1, 4'd0, 1'b0, 3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1);
    op_both("remu_by_zero", 1'b1, 4'd0, 1'b0, 3'd7, 32'd9, 32'd0, 32'd9, 1, 1);
    op_both("div_ovf", 1'b1, 4'd0, 1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
            1, 1);
    op_both("rem_ovf", 1'b1, 4'd0, 1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
    op_both("mulh", 1'b1, 4'd0, 1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,
            34, 1);
    op_both("mulhu", 1'b1, 4'd0, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
            34, 1);
    op_both("mul", 1'b1, 4'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
            34, 1);
    op_both("mulhsu", 1'b1, 4'd0, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 1);
    op_both("sra", 1'b0, 4'd7, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1);

    kill_mid_calc(1'b0);
    kill_mid_calc(1'b1);

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_md     = ($urandom_range(0, 2) == 0);
      op        = 4'($urandom_range(0, 15));
      in_inv    = 1'($urandom);
      f3        = 3'($urandom);
      a         = pick();
      b         = pick();
      tag       = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      @(posedge clk);
      #1;
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
